// File: rtl/mul_seq_ctrl_pkg.sv
// Shared types for the multiply sequencer: opcode and FSM state enums plus the default watchdog limit.
package mul_ctrl_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BUSY,
        DRAIN,
        RESP
    } mul_ctrl_state_e;

    localparam int MUL_CTRL_DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Bundle of the EX-side request/response signals and the multiplier start/done signals.
// slave is the controller's view; master is the EX stage plus multiplier.
interface mul_seq_ctrl_if;
    import mul_ctrl_pkg::*;

    logic        req_valid;
    logic        req_ready;
    mul_op_e     req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [4:0]  req_rd;
    logic        flush;
    logic        stall;

    logic        mul_start;
    mul_op_e     mul_op;
    logic [31:0] mul_op1;
    logic [31:0] mul_op2;
    logic        mul_done;
    logic [31:0] mul_result;

    logic        rsp_valid;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_data;

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, req_rd, flush, mul_done, mul_result,
        output req_ready, stall, mul_start, mul_op, mul_op1, mul_op2, rsp_valid, rsp_rd, rsp_data
    );

    modport master (
        output req_valid, req_op, req_rs1, req_rs2, req_rd, flush, mul_done, mul_result,
        input  req_ready, stall, mul_start, mul_op, mul_op1, mul_op2, rsp_valid, rsp_rd, rsp_data
    );

endinterface

// File: rtl/mul_seq_ctrl_reuse_cache.sv
// Single-entry cache of the last completed multiply; built only when MUL_RESULT_REUSE_EN is defined.
`ifdef MUL_RESULT_REUSE_EN
module mul_reuse_cache
    import mul_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  mul_op_e     lookup_op,
    input  logic [31:0] lookup_rs1,
    input  logic [31:0] lookup_rs2,
    output logic        hit,
    output logic [31:0] hit_data,
    input  logic        update,
    input  mul_op_e     upd_op,
    input  logic [31:0] upd_rs1,
    input  logic [31:0] upd_rs2,
    input  logic [31:0] upd_result,
    input  logic        invalidate
);

    mul_op_e     ent_op;
    logic [31:0] ent_rs1;
    logic [31:0] ent_rs2;
    logic [31:0] ent_result;
    logic        ent_valid;

    // A timeout means the multiplier is suspect, so the cached result is dropped too
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_op     <= MUL;
            ent_rs1    <= '0;
            ent_rs2    <= '0;
            ent_result <= '0;
            ent_valid  <= 1'b0;
        end else if (invalidate) begin
            ent_valid  <= 1'b0;
        end else if (update) begin
            ent_op     <= upd_op;
            ent_rs1    <= upd_rs1;
            ent_rs2    <= upd_rs2;
            ent_result <= upd_result;
            ent_valid  <= 1'b1;
        end
    end

    assign hit      = ent_valid && (lookup_op == ent_op) && (lookup_rs1 == ent_rs1) && (lookup_rs2 == ent_rs2);
    assign hit_data = ent_result;

endmodule
`endif

// File: rtl/mul_seq_ctrl.sv
// Sequencer between EX and the shared iterative multiplier, with flush draining and a watchdog.
// Define MUL_RESULT_REUSE_EN to answer a repeat of the last completed multiply without launching it.
module mul_seq_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = MUL_CTRL_DEFAULT_TIMEOUT,
    parameter int CNT_W          = 7
) (
    input  logic          clk,
    input  logic          rst,
    mul_seq_ctrl_if.slave bus,
    output logic          err_timeout
);

    mul_ctrl_state_e  state;
    logic [CNT_W-1:0] wd_cnt;
    logic             accept;
    logic             wd_fire;
    logic             cache_hit;
    logic [31:0]      cache_data;

    assign bus.req_ready = (state == IDLE);
    assign bus.stall     = bus.req_valid & ~bus.req_ready;
    assign accept        = bus.req_valid & ~bus.flush & (state == IDLE);
    assign wd_fire       = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef MUL_RESULT_REUSE_EN
    logic cache_update;
    logic cache_invalidate;

    assign cache_update     = (state == BUSY) & bus.mul_done & ~bus.flush;
    assign cache_invalidate = ((state == BUSY) | (state == DRAIN)) & ~bus.mul_done & wd_fire;

    mul_reuse_cache u_cache (
        .clk        (clk),
        .rst        (rst),
        .lookup_op  (bus.req_op),
        .lookup_rs1 (bus.req_rs1),
        .lookup_rs2 (bus.req_rs2),
        .hit        (cache_hit),
        .hit_data   (cache_data),
        .update     (cache_update),
        .upd_op     (bus.mul_op),
        .upd_rs1    (bus.mul_op1),
        .upd_rs2    (bus.mul_op2),
        .upd_result (bus.mul_result),
        .invalidate (cache_invalidate)
    );
`else
    assign cache_hit  = 1'b0;
    assign cache_data = '0;
`endif

    // Watchdog counts BUSY/DRAIN cycles; the fire check sees the cycle that would make it reach the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            wd_cnt        <= '0;
            err_timeout   <= 1'b0;
            bus.mul_start <= 1'b0;
            bus.mul_op    <= MUL;
            bus.mul_op1   <= '0;
            bus.mul_op2   <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rd    <= '0;
            bus.rsp_data  <= '0;
        end else begin
            bus.mul_start <= 1'b0;
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.mul_op  <= bus.req_op;
                        bus.mul_op1 <= bus.req_rs1;
                        bus.mul_op2 <= bus.req_rs2;
                        bus.rsp_rd  <= bus.req_rd;
                        if (cache_hit) begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_data  <= cache_data;
                            state         <= RESP;
                        end else begin
                            bus.mul_start <= 1'b1;
                            wd_cnt        <= '0;
                            state         <= START;
                        end
                    end
                end
                START: begin
                    state <= bus.flush ? DRAIN : BUSY;
                end
                BUSY: begin
                    if (bus.mul_done) begin
                        if (bus.flush) begin
                            state <= IDLE;
                        end else begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_data  <= bus.mul_result;
                            state         <= RESP;
                        end
                    end else if (wd_fire) begin
                        err_timeout   <= 1'b1;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= '0;
                        state         <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                        if (bus.flush) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.mul_done) begin
                        state <= IDLE;
                    end else if (wd_fire) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: a vector table of multiplies plus hand sequences for flush,
// back-to-back stall, watchdog, reset mid-op and (with MUL_RESULT_REUSE_EN) result reuse.
module tb_mul_seq_ctrl;
    import mul_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic err_timeout;

    mul_seq_ctrl_if bus ();

    mul_seq_ctrl #(
        .TIMEOUT_CYCLES (64),
        .CNT_W          (7)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        mul_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        int          lat;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];

    int n_pass  = 0;
    int n_total = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_start = 0;
    int          n_rsp   = 0;
    int          last_start_cyc = -1;
    int          last_rsp_cyc   = -1;
    logic [31:0] last_rsp_data;
    logic [4:0]  last_rsp_rd;

    always @(negedge clk) begin
        if (bus.mul_start === 1'b1) begin
            n_start        = n_start + 1;
            last_start_cyc = cyc;
        end
        if (bus.rsp_valid === 1'b1) begin
            n_rsp         = n_rsp + 1;
            last_rsp_cyc  = cyc;
            last_rsp_data = bus.rsp_data;
            last_rsp_rd   = bus.rsp_rd;
        end
    end

    function automatic logic [31:0] calc(input mul_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (op)
            MUL:     begin p = {32'b0, a} * {32'b0, b};               return p[31:0];  end
            MULH:    begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b};   return p[63:32]; end
            MULHSU:  begin p = {{32{a[31]}}, a} * {32'b0, b};         return p[63:32]; end
            default: begin p = {32'b0, a} * {32'b0, b};               return p[63:32]; end
        endcase
    endfunction

    // Multiplier stand-in: done pulse stub_lat cycles after the start cycle, suppressible for the watchdog test
    int          stub_lat   = 1;
    bit          stub_en    = 1'b1;
    bit          force_done = 1'b0;
    int          pend       = 0;
    logic [31:0] stub_res   = '0;

    always @(negedge clk) begin
        bus.mul_done   = 1'b0;
        bus.mul_result = 32'hDEADBEEF;
        if (rst) begin
            pend = 0;
        end else if (bus.mul_start === 1'b1) begin
            pend     = stub_lat;
            stub_res = calc(bus.mul_op, bus.mul_op1, bus.mul_op2);
        end else if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0 && stub_en) begin
                bus.mul_done   = 1'b1;
                bus.mul_result = stub_res;
            end
        end
        if (force_done) bus.mul_done = 1'b1;
    end

    task automatic next_cycle();
        @(negedge clk);
        #2;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total = n_total + 1;
        if (act !== exp) $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        else n_pass = n_pass + 1;
    endtask

    task automatic drive_req(input mul_op_e op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_rs1   = a;
        bus.req_rs2   = b;
        bus.req_rd    = rd;
    endtask

    // Issues one request from IDLE and lets it run to completion plus one idle cycle
    task automatic apply_stimulus(input mul_op_e op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] rd, input int lat,
                                  output int acc, output int s0, output int r0);
        stub_lat = lat;
        s0 = n_start;
        r0 = n_rsp;
        drive_req(op, a, b, rd);
        acc = cyc;
        next_cycle();
        bus.req_valid = 1'b0;
        repeat (lat + 3) next_cycle();
    endtask

    initial begin
        int acc, s0, r0;
        logic err64;
        logic err66;
        bit   stall_ok;

        vecs[0] = '{MUL,    32'd7,        32'd6,        5'd3,  1, 32'd42};
        vecs[1] = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  2, 32'hFFFFFFFE};
        vecs[2] = '{MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  3, 32'h00000001};
        vecs[3] = '{MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  4, 32'h00000000};
        vecs[4] = '{MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  1, 32'hFFFFFFFF};
        vecs[5] = '{MULH,   32'h80000000, 32'h80000000, 5'd8,  2, 32'h40000000};
        vecs[6] = '{MUL,    32'h12345678, 32'h00000010, 5'd31, 3, 32'h23456780};
        vecs[7] = '{MULHU,  32'h80000000, 32'h00000004, 5'd1,  5, 32'h00000002};

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = MUL;
        bus.req_rs1   = '0;
        bus.req_rs2   = '0;
        bus.req_rd    = '0;
        bus.flush     = 1'b0;
        repeat (2) next_cycle();
        rst = 1'b0;
        next_cycle();

        check_output("reset_req_ready", 32'(bus.req_ready), 32'd1);
        check_output("reset_stall",     32'(bus.stall),     32'd0);
        check_output("reset_mul_start", 32'(bus.mul_start), 32'd0);
        check_output("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_output("reset_err",       32'(err_timeout),   32'd0);
        check_output("reset_mul_op1",   bus.mul_op1,        32'd0);
        check_output("reset_rsp_data",  bus.rsp_data,       32'd0);
        check_output("reset_rsp_rd",    32'(bus.rsp_rd),    32'd0);

        // Stray done in IDLE must not create a response
        r0 = n_rsp;
        force_done = 1'b1;
        next_cycle();
        force_done = 1'b0;
        next_cycle();
        next_cycle();
        check_output("idle_done_rsp",   n_rsp - r0,         32'd0);
        check_output("idle_done_ready", 32'(bus.req_ready), 32'd1);

        // Flush in IDLE blocks the accept
        s0 = n_start;
        drive_req(MUL, 32'd3, 32'd3, 5'd2);
        bus.flush = 1'b1;
        next_cycle();
        check_output("idle_flush_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        next_cycle();
        check_output("idle_flush_start", n_start - s0, 32'd0);

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].lat, acc, s0, r0);
            check_output($sformatf("v%0d_starts", i),    n_start - s0,         32'd1);
            check_output($sformatf("v%0d_start_cyc", i), last_start_cyc,       acc + 1);
            check_output($sformatf("v%0d_mul_op", i),    32'(bus.mul_op),      32'(vecs[i].op));
            check_output($sformatf("v%0d_mul_op1", i),   bus.mul_op1,          vecs[i].a);
            check_output($sformatf("v%0d_mul_op2", i),   bus.mul_op2,          vecs[i].b);
            check_output($sformatf("v%0d_rsps", i),      n_rsp - r0,           32'd1);
            check_output($sformatf("v%0d_rsp_cyc", i),   last_rsp_cyc,         acc + 2 + vecs[i].lat);
            check_output($sformatf("v%0d_rsp_data", i),  last_rsp_data,        vecs[i].exp);
            check_output($sformatf("v%0d_rsp_rd", i),    32'(last_rsp_rd),     32'(vecs[i].rd));
            check_output($sformatf("v%0d_ready", i),     32'(bus.req_ready),   32'd1);
        end

        // Back-to-back: second request waits with stall high until the IDLE cycle after RESP
        stub_lat = 2;
        s0 = n_start;
        r0 = n_rsp;
        drive_req(MUL, 32'd3, 32'd5, 5'd11);
        acc = cyc;
        next_cycle();
        drive_req(MUL, 32'd7, 32'd6, 5'd12);
        stall_ok = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            if (bus.stall !== 1'b1) stall_ok = 1'b0;
            if (k < 4) next_cycle();
        end
        next_cycle();
        check_output("b2b_stall_window",  32'(stall_ok),      32'd1);
        check_output("b2b_stall_release", 32'(bus.stall),     32'd0);
        check_output("b2b_first_data",    last_rsp_data,      32'd15);
        next_cycle();
        bus.req_valid = 1'b0;
        repeat (5) next_cycle();
        check_output("b2b_starts",     n_start - s0,      32'd2);
        check_output("b2b_start2_cyc", last_start_cyc,    acc + 6);
        check_output("b2b_rsps",       n_rsp - r0,        32'd2);
        check_output("b2b_rsp2_cyc",   last_rsp_cyc,      acc + 9);
        check_output("b2b_rsp2_data",  last_rsp_data,     32'd42);
        check_output("b2b_rsp2_rd",    32'(last_rsp_rd),  32'd12);

`ifdef MUL_RESULT_REUSE_EN
        apply_stimulus(MUL, 32'd7, 32'd6, 5'd9, 2, acc, s0, r0);
        check_output("reuse_hit_starts",  n_start - s0,      32'd0);
        check_output("reuse_hit_rsps",    n_rsp - r0,        32'd1);
        check_output("reuse_hit_rsp_cyc", last_rsp_cyc,      acc + 1);
        check_output("reuse_hit_data",    last_rsp_data,     32'd42);
        check_output("reuse_hit_rd",      32'(last_rsp_rd),  32'd9);
        apply_stimulus(MUL, 32'd7, 32'd5, 5'd10, 2, acc, s0, r0);
        check_output("reuse_miss_starts",  n_start - s0,  32'd1);
        check_output("reuse_miss_rsp_cyc", last_rsp_cyc,  acc + 4);
        check_output("reuse_miss_data",    last_rsp_data, 32'd35);
`endif

        // Flush 5 cycles after accept: op drains, ready returns the cycle after mul_done
        stub_lat = 10;
        s0 = n_start;
        r0 = n_rsp;
        drive_req(MUL, 32'd9, 32'd9, 5'd13);
        acc = cyc;
        next_cycle();
        bus.req_valid = 1'b0;
        repeat (4) next_cycle();
        bus.flush = 1'b1;
        next_cycle();
        bus.flush = 1'b0;
        repeat (5) next_cycle();
        check_output("drain_ready_at_done",    32'(bus.req_ready), 32'd0);
        next_cycle();
        check_output("drain_ready_after_done", 32'(bus.req_ready), 32'd1);
        repeat (2) next_cycle();
        check_output("drain_rsps",   n_rsp - r0,   32'd0);
        check_output("drain_starts", n_start - s0, 32'd1);

        // Flush coincident with mul_done: result dropped, IDLE next cycle
        stub_lat = 3;
        r0 = n_rsp;
        drive_req(MUL, 32'd2, 32'd3, 5'd14);
        acc = cyc;
        next_cycle();
        bus.req_valid = 1'b0;
        repeat (3) next_cycle();
        bus.flush = 1'b1;
        next_cycle();
        bus.flush = 1'b0;
        check_output("sameflush_ready", 32'(bus.req_ready), 32'd1);
        repeat (3) next_cycle();
        check_output("sameflush_rsps", n_rsp - r0, 32'd0);

        // Watchdog: no done at all; 64 BUSY cycles then a zero response and sticky error
        stub_en = 1'b0;
        r0 = n_rsp;
        err64 = 1'bx;
        err66 = 1'bx;
        drive_req(MULHU, 32'd100, 32'd200, 5'd15);
        acc = cyc;
        next_cycle();
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            if (cyc == acc + 64) err64 = err_timeout;
            if (cyc == acc + 66) err66 = err_timeout;
            next_cycle();
        end
        check_output("wd_err_before", 32'(err64),         32'd0);
        check_output("wd_err_fired",  32'(err66),         32'd1);
        check_output("wd_rsps",       n_rsp - r0,         32'd1);
        check_output("wd_rsp_cyc",    last_rsp_cyc,       acc + 66);
        check_output("wd_rsp_data",   last_rsp_data,      32'd0);
        check_output("wd_rsp_rd",     32'(last_rsp_rd),   32'd15);
        check_output("wd_ready",      32'(bus.req_ready), 32'd1);
        stub_en = 1'b1;
        apply_stimulus(MUL, 32'd2, 32'd8, 5'd16, 2, acc, s0, r0);
        check_output("wd_next_rsps", n_rsp - r0,       32'd1);
        check_output("wd_next_data", last_rsp_data,    32'd16);
        check_output("wd_sticky",    32'(err_timeout), 32'd1);

        // Asynchronous reset in the middle of an op
        stub_lat = 6;
        drive_req(MUL, 32'd5, 32'd5, 5'd17);
        next_cycle();
        bus.req_valid = 1'b0;
        repeat (2) next_cycle();
        rst = 1'b1;
        #1;
        check_output("rst_mid_ready", 32'(bus.req_ready), 32'd1);
        check_output("rst_mid_err",   32'(err_timeout),   32'd0);
        check_output("rst_mid_rsp",   32'(bus.rsp_valid), 32'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        apply_stimulus(MUL, 32'h10, 32'h10, 5'd18, 1, acc, s0, r0);
        check_output("post_rst_rsps", n_rsp - r0,    32'd1);
        check_output("post_rst_data", last_rsp_data, 32'd256);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
